// File: rtl/out_uart_tx.sv
// -----------------------------------------------------------------------------
// out_uart_tx
//
// Output-side peripheral that sits behind the core's output port. Every 16-bit
// word the core writes is buffered in a small FIFO and sent on a UART TX line,
// 8N1, as two bytes: high byte first, then low byte. Once the core halts, the
// drained flag reports that every buffered word has left the line.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   FIFO_DEPTH   : number of buffered 16-bit words (power of two, 2..64)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   out_en     in   core output strobe, one word per cycle while high
//   out_dat    in   core output word, valid when out_en=1
//   is_halt    in   core halted (level)
//   tx         out  UART serial line, idle high, driven from a flop
//   busy       out  serialiser is sending a frame (not IDLE)
//   fifo_count out  words currently buffered
//   overflow   out  sticky: a write was dropped because the FIFO was full
//   drained    out  is_halt=1, FIFO empty and serialiser idle
// -----------------------------------------------------------------------------
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              out_en,
  input  logic [15:0]                       out_dat,
  input  logic                              is_halt,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              drained
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   baud_q,     baud_d;
  logic [2:0]         bit_q,      bit_d;
  logic               hi_lo_q,    hi_lo_d;    // 0 = high byte, 1 = low byte
  logic [15:0]        hold_q,     hold_d;     // word being serialised
  logic               tx_q,       tx_d;
  logic               busy_q,     busy_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]      count_q,    count_d;
  logic               overflow_q, overflow_d;

  logic [15:0]        fifo_mem [FIFO_DEPTH];

  logic               pop;
  logic               push;
  logic               bit_end;
  logic [7:0]         tx_byte;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    hi_lo_d    = hi_lo_q;
    hold_d     = hold_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = 1'b0;

    bit_end = (baud_q == BAUD_LAST);

    // Serialiser. The baud counter restarts on every bit transition so each
    // level on the line lasts exactly CLKS_PER_BIT cycles.
    unique case (state_q)
      IDLE: begin
        // Pop in the same cycle IDLE sees a non-empty FIFO; the start bit
        // appears on the line the very next cycle.
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = fifo_mem[rd_ptr_q];
          hi_lo_d = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!hi_lo_q) begin
            // Low byte follows straight on, with no idle gap.
            hi_lo_d = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // FIFO. A write into a full FIFO still fits when the head leaves in the
    // same cycle; otherwise it is dropped and flagged.
    push       = out_en && ((count_q != DEPTH_C) || pop);
    overflow_d = overflow_q | (out_en & ~push);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;   // power-of-two depth: natural wrap
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Line level is computed from the next state so that tx comes straight
    // out of a flop yet lines up with the state it belongs to.
    tx_byte = hi_lo_d ? hold_d[7:0] : hold_d[15:8];
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_byte[bit_d];
      default: tx_d = 1'b1;              // IDLE and STOP
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      hi_lo_q    <= 1'b0;
      hold_q     <= 16'h0000;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      hi_lo_q    <= hi_lo_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count
  // already discards its contents, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= out_dat;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drained    = is_halt & (count_q == '0) & (state_q == IDLE);

endmodule

// File: tb/tb_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_out_uart_tx
//
// Bench for out_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4. Inputs are
// driven and outputs sampled on the falling clock edge. A behavioural UART
// receiver decodes the line into byte records; a word-level model (a queue of
// words plus the start time of the frame on the line) predicts every output
// cycle by cycle during the randomized phases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FRAME = 20 * CPB;           // cycles per word on the line

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          out_en  = 1'b0;
  logic [15:0]   out_dat = 16'h0000;
  logic          is_halt = 1'b0;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          drained;

  out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_en     (out_en),
    .out_dat    (out_dat),
    .is_halt    (is_halt),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line level at cycle 'off' of a word frame: 20 bit slots of CPB cycles,
  // slots 0..9 carry the high byte frame, 10..19 the low byte frame.
  function automatic logic frame_bit(input logic [15:0] w, input int off);
    int         slot;
    int         s;
    logic [7:0] b;
    slot = off / CPB;
    s    = slot % 10;
    b    = (slot < 10) ? w[15:8] : w[7:0];
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return b[s-1];
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural UART receiver: samples the middle of every bit.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         start;
    logic [7:0] data;
    logic       stop;
  } rx_rec_t;

  rx_rec_t    rx_q[$];
  rx_rec_t    rx_rec;
  int         cyc      = 0;
  int         rx_cnt   = -1;
  int         rx_start = 0;
  logic [7:0] rx_sh    = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (tx === 1'b0) begin
        rx_cnt   = 0;
        rx_start = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt <= 8*CPB + CPB/2 && (rx_cnt % CPB) == CPB/2)
        rx_sh[(rx_cnt - CPB - CPB/2) / CPB] = tx;
      if (rx_cnt == 9*CPB + CPB/2) begin
        rx_rec.start = rx_start;
        rx_rec.data  = rx_sh;
        rx_rec.stop  = tx;
        rx_q.push_back(rx_rec);
      end
      if (rx_cnt == 10*CPB - 1) rx_cnt = -1;
    end
  end

  // ---------------------------------------------------------------------------
  // Word-level reference model
  // ---------------------------------------------------------------------------
  logic [15:0] m_q[$];
  logic [15:0] m_hold;
  int          m_n;
  int          m_fs;
  logic        m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_hold = 16'h0000;
    m_n    = 0;
    m_fs   = -1000000;
    m_ovf  = 1'b0;
  endtask

  function automatic bit model_active();
    int off;
    off = m_n - m_fs;
    return (off >= 0) && (off < FRAME);
  endfunction

  // One clock edge: the line takes a new word whenever it is free, and a
  // write is accepted if there is room after that.
  task automatic model_edge(input logic en, input logic [15:0] dat);
    if (!model_active() && m_q.size() > 0) begin
      m_hold = m_q.pop_front();
      m_fs   = m_n + 1;
    end
    if (en) begin
      if (m_q.size() < DEPTH) m_q.push_back(dat);
      else                    m_ovf = 1'b1;
    end
    m_n++;
  endtask

  task automatic model_compare();
    bit act;
    act = model_active();
    check("rnd_tx",       tx,         act ? frame_bit(m_hold, m_n - m_fs) : 1'b1);
    check("rnd_busy",     busy,       act);
    check("rnd_count",    fifo_count, m_q.size());
    check("rnd_overflow", overflow,   m_ovf);
    check("rnd_drained",  drained,    is_halt && (m_q.size() == 0) && !act);
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset   = 1'b1;
    out_en  = 1'b0;
    is_halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int lim, input string name);
    int t;
    t = 0;
    while (rx_q.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic wait_drain(input int lim, input string name);
    int t;
    t = 0;
    while ((busy !== 1'b0 || fifo_count !== '0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    check(name, (t < lim), 1'b1);
  endtask

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs[4];
  int   pcts[3];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t;

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h1234, 8'h12, 8'h34};
    vecs[2] = '{16'hFF00, 8'hFF, 8'h00};
    vecs[3] = '{16'h8001, 8'h80, 8'h01};
    pcts[0] = 3;
    pcts[1] = 20;
    pcts[2] = 70;

    // ---- Reset release, no writes ------------------------------------------
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      is_halt = (i % 3 == 1);
      #1;
      check("idle_tx",       tx,         1'b1);
      check("idle_busy",     busy,       1'b0);
      check("idle_count",    fifo_count, 0);
      check("idle_overflow", overflow,   1'b0);
      check("idle_drained",  drained,    is_halt);
      @(negedge clk);
    end
    is_halt = 1'b0;

    // ---- Single words from the table, every line cycle checked -------------
    for (int v = 0; v < 4; v++) begin
      out_en  = 1'b1;
      out_dat = vecs[v].word;
      @(negedge clk);
      out_en = 1'b0;
      check($sformatf("vec%0d_count_pulse", v), fifo_count, 1);
      check($sformatf("vec%0d_pre_tx", v),      tx,         1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_count_popped", v), fifo_count, 0);
      for (int c = 0; c < FRAME; c++) begin
        check($sformatf("vec%0d_tx_c%0d", v, c),   tx,   frame_bit({vecs[v].hi, vecs[v].lo}, c));
        check($sformatf("vec%0d_busy_c%0d", v, c), busy, 1'b1);
        @(negedge clk);
      end
      check($sformatf("vec%0d_busy_end", v), busy, 1'b0);
      check($sformatf("vec%0d_tx_end", v),   tx,   1'b1);
    end

    // ---- Six consecutive writes: fill, overflow, order, spacing ------------
    rx_q.delete();
    out_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      out_dat = 16'(k);
      @(negedge clk);
      if (k == 5) begin
        check("burst_count_full",  fifo_count, 4);
        check("burst_ovf_before",  overflow,   1'b0);
      end
    end
    out_en = 1'b0;
    check("burst_count_after_drop", fifo_count, 4);
    check("burst_ovf_set",          overflow,   1'b1);
    wait_bytes(10, 1000, "burst_byte_count");
    for (int j = 0; j < 10; j++) begin
      if (j < rx_q.size()) begin
        check($sformatf("burst_byte%0d", j), rx_q[j].data, (j % 2 == 0) ? 0 : (j / 2 + 1));
        check($sformatf("burst_stop%0d", j), rx_q[j].stop, 1'b1);
        check($sformatf("burst_start%0d", j), rx_q[j].start - rx_q[0].start,
              (j / 2) * (FRAME + 1) + (j % 2) * (FRAME / 2));
      end
    end
    wait_drain(200, "burst_drain");
    check("burst_ovf_sticky", overflow, 1'b1);

    // ---- Full FIFO, write in the pop cycle ---------------------------------
    do_reset();
    check("full_ovf_cleared", overflow, 1'b0);
    out_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      out_dat = 16'h0100 + 16'(k);
      @(negedge clk);
    end
    out_en = 1'b0;
    check("full_count",   fifo_count, 4);
    check("full_ovf_pre", overflow,   1'b0);
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("full_pop_wait",  (t < 200), 1'b1);
    check("full_pop_count", fifo_count, 4);
    out_en  = 1'b1;
    out_dat = 16'h0BEE;
    @(negedge clk);
    out_en = 1'b0;
    check("full_push_pop_count", fifo_count, 4);
    check("full_push_pop_ovf",   overflow,   1'b0);
    check("full_push_pop_busy",  busy,       1'b1);
    wait_bytes(12, 1200, "full_byte_count");
    if (rx_q.size() >= 12) begin
      check("full_byte9",  rx_q[9].data,  8'h05);
      check("full_byte10", rx_q[10].data, 8'h0B);
      check("full_byte11", rx_q[11].data, 8'hEE);
    end
    wait_drain(200, "full_drain");

    // ---- Reset in the middle of a data bit ---------------------------------
    do_reset();
    out_en  = 1'b1;
    out_dat = 16'h1234;
    @(negedge clk);
    out_dat = 16'h5678;
    @(negedge clk);
    out_en = 1'b0;
    repeat (5) @(negedge clk);               // frame cycle 5: high byte bit 0
    check("midrst_tx_before",    tx,         1'b0);
    check("midrst_busy_before",  busy,       1'b1);
    check("midrst_count_before", fifo_count, 1);
    reset = 1'b1;
    #1;
    check("midrst_tx_async",    tx,         1'b1);
    check("midrst_busy_async",  busy,       1'b0);
    check("midrst_count_async", fifo_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check("midrst_tx_quiet",   tx,   1'b1);
      check("midrst_busy_quiet", busy, 1'b0);
      @(negedge clk);
    end
    check("midrst_count_after", fifo_count, 0);
    check("midrst_no_bytes",    rx_q.size(), 0);

    // ---- Halt and drain ----------------------------------------------------
    rx_q.delete();
    out_en  = 1'b1;
    out_dat = 16'h00FF;
    @(negedge clk);
    out_en  = 1'b0;
    is_halt = 1'b1;
    #1;
    check("halt_drained_queued", drained, 1'b0);
    @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      check($sformatf("halt_drained_c%0d", c), drained, 1'b0);
      @(negedge clk);
    end
    check("halt_drained_final", drained,    1'b1);
    check("halt_busy_final",    busy,       1'b0);
    check("halt_count_final",   fifo_count, 0);
    check("halt_byte_count",    rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("halt_byte_hi", rx_q[0].data, 8'h00);
      check("halt_byte_lo", rx_q[1].data, 8'hFF);
    end
    is_halt = 1'b0;
    #1;
    check("halt_drained_release", drained, 1'b0);
    @(negedge clk);

    // ---- Randomized traffic against the word-level model -------------------
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      model_reset();
      for (int n = 0; n < 1500; n++) begin
        logic       en;
        logic [15:0] dat;
        model_compare();
        en  = ($urandom_range(0, 99) < pcts[(n / 200 + ph) % 3]);
        dat = 16'($urandom);
        if ($urandom_range(0, 49) == 0) is_halt = ~is_halt;
        out_en  = en;
        out_dat = dat;
        model_edge(en, dat);
        @(negedge clk);
      end
      out_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Output-side peripheral downstream of the core's output port. Captures every 16-bit word the core writes (out_en/out_dat) into a small FIFO and serialises it on a UART TX line, 8N1.
- Each word is sent as two bytes: high byte first, then low byte.
- Lets the core emit results at full speed while a host terminal reads them; reports drain status once the core halts.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
- FIFO_DEPTH, 8, number of 16-bit words buffered; power of two, 2..64.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- out_en  in  1  core output strobe; one word per cycle while high.
- out_dat  in  16  core output word, valid when out_en=1.
- is_halt  in  1  core halted (level).
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while the serialiser is outside IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently buffered.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- drained  out  1  is_halt=1, FIFO empty and serialiser in IDLE.

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE.
  - Baud counter, bit index and byte select cleared; FIFO contents discarded.
  - A partially sent frame is abandoned, and the line returns high immediately.
- FIFO:
  - Synchronous push on the clk edge when out_en=1.
  - Push is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set to 1 and stays 1 until reset.
  - Same-cycle push+pop leaves fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH; FIFO order is strict.
- Serialiser FSM: IDLE, START, DATA, STOP. A hi_lo flag selects the byte (0 = high byte, 1 = low byte).
  - IDLE, fifo_count>0: pop the head word into a 16-bit holding register, set hi_lo=0, go to START. The pop occurs in the same cycle that IDLE is observed with a non-empty FIFO.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = selected byte[bit index], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - if hi_lo=0: set hi_lo=1 and go directly to START (no idle gap between the two bytes);
    - if hi_lo=1: go to IDLE.
  - Timing:
    - Frame = 10*CLKS_PER_BIT cycles per byte; 20*CLKS_PER_BIT cycles per word.
    - The first start-bit cycle is the cycle after the pop.
    - Back-to-back words have exactly one IDLE cycle (tx=1) between the stop bit of the low byte and the next start bit.
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit transition. It is sized $clog2(CLKS_PER_BIT).
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- drained is combinational from is_halt, fifo_count==0 and state==IDLE.
- is_halt does not block pushes: words written in the halt cycle are still sent.
- tx is driven from a register (glitch-free).

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset release, no writes -> tx=1, busy=0, fifo_count=0, drained follows is_halt for 20 cycles.
- Single write 0xA55A -> fifo_count pulses to 1 for one cycle. tx shows:
  - start bit 0;
  - high byte 0xA5 bits 1,0,1,0,0,1,0,1;
  - stop bit 1;
  - start bit 0;
  - low byte 0x5A bits 0,1,0,1,1,0,1,0;
  - stop bit 1.
  Each level lasts 4 cycles, 80 cycles total; busy falls the cycle after the last stop bit.
- Six consecutive writes 0x0001..0x0006 while IDLE -> first word popped immediately. Words 2-5 fill the FIFO (count=4), word 6 is dropped and overflow=1. Output bytes are 00 01 00 02 00 03 00 04 00 05, with one idle cycle between words.
- FIFO full (count=4) during transmission; write coincides with the pop cycle -> write accepted, count stays 4, overflow stays 0.
- Assert reset mid-DATA of word 0x1234 -> tx=1 and busy=0 immediately (asynchronous). After release, nothing further is sent; fifo_count=0.
- Write 0x00FF, then raise is_halt -> drained=0 while sending. drained=1 the first cycle state is IDLE with an empty FIFO, about 80 cycles after the write.
